// File: rtl/tile_cfg_pkg.sv
// tile_cfg_pkg: shared types and constants for the tile bl/wl configuration
// controller.
//   state_t     - controller FSM states
//   CRC16_POLY  - CRC-16-CCITT polynomial
//   CRC16_INIT  - CRC-16-CCITT seed
//   cnt_w()     - counter width for a counter that must hold 0..n-1 (min 1 bit)
package tile_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    PULSE = 3'd3,
    HOLD  = 3'd4,
    CRC   = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tile_cfg_crc16.sv
// tile_cfg_crc16: CRC-16-CCITT over DATA_W-bit words, bits fed LSB first.
//   clk, rst : clock, async active-high reset (reset value CRC16_INIT)
//   clr      : reload CRC16_INIT
//   en       : fold data into the running CRC
//   data     : input word
//   crc      : running CRC value
module tile_cfg_crc16
  import tile_cfg_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [15:0]       crc
);

  logic [15:0] crc_nxt;

  // Bit-serial MSB-out shift register unrolled over one word; the word's
  // bit 0 enters first.
  always_comb begin
    crc_nxt = crc;
    for (int j = 0; j < DATA_W; j++) begin
      if (crc_nxt[15] ^ data[j]) crc_nxt = {crc_nxt[14:0], 1'b0} ^ CRC16_POLY;
      else                       crc_nxt = {crc_nxt[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= CRC16_INIT;
    else if (clr) crc <= CRC16_INIT;
    else if (en)  crc <= crc_nxt;
  end

endmodule

// File: rtl/tile_blwl_cfg_ctrl.sv
// tile_blwl_cfg_ctrl: programs a tile's memory-bank config cells row by row.
// Words arrive on a valid/ready stream, WPR = ceil(NUM_BL/DATA_W) of them form
// one row (bit j of word k -> bl[k*DATA_W+j]), then the row's wordline is
// strobed for WL_PULSE cycles between one-cycle SETUP and HOLD guard cycles.
//   prog_clk, pReset : clock, async active-high reset
//   cfg_start        : start pulse (ignored while busy)
//   cfg_abort        : synchronous abort back to IDLE
//   cfg_data/valid   : word stream in; cfg_ready high in LOAD (and CRC)
//   bl, wl           : bitline data and one-hot wordline strobe to the tile
//   cfg_busy         : any state but IDLE
//   cfg_done         : one-cycle pulse on successful completion
//   cfg_err          : sticky CRC mismatch, cleared by cfg_start
// Build option: define CFG_CRC_EN to check a trailing CRC-16 after the last
// row; without it cfg_err is tied 0 and no CRC logic exists.
module tile_blwl_cfg_ctrl
  import tile_cfg_pkg::*;
#(
  parameter int NUM_BL   = 80,
  parameter int NUM_WL   = 80,
  parameter int DATA_W   = 8,
  parameter int WL_PULSE = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic [0:NUM_BL-1] bl,
  output logic [0:NUM_WL-1] wl,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int WPR    = (NUM_BL + DATA_W - 1) / DATA_W;
  localparam int CW     = (16 + DATA_W - 1) / DATA_W;
`ifdef CFG_CRC_EN
  localparam int WC_MAX = (WPR > CW) ? WPR : CW;
`else
  localparam int WC_MAX = WPR;
`endif
  localparam int ROW_W  = cnt_w(NUM_WL);
  localparam int WRD_W  = cnt_w(WC_MAX);
  localparam int PLS_W  = cnt_w(WL_PULSE);
  localparam int COL_W  = WPR * DATA_W;

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [WRD_W-1:0]   wcnt;
  logic [PLS_W-1:0]   pcnt;
  logic [COL_W-1:0]   col, col_nxt;
  logic               xfer;
  logic               last_row;

  assign xfer     = cfg_valid && cfg_ready;
  assign last_row = (row == ROW_W'(NUM_WL - 1));
  assign cfg_busy = (state != IDLE);

  // Column register with the current word merged in, so the last word of a
  // row reaches bl in the same edge that enters SETUP.
  for (genvar k = 0; k < WPR; k++) begin : g_col
    assign col_nxt[k*DATA_W +: DATA_W] =
      (wcnt == WRD_W'(k)) ? cfg_data : col[k*DATA_W +: DATA_W];
  end

`ifdef CFG_CRC_EN
  localparam int EXP_W = CW * DATA_W;

  logic [15:0]      crc;
  logic [EXP_W-1:0] exp_crc, exp_nxt;
  logic             crc_clr, crc_en, crc_ok;

  assign cfg_ready = (state == LOAD) || (state == CRC);
  assign crc_clr   = (state == IDLE) && cfg_start;
  // Only row data feeds the CRC; aborted transfers never count.
  assign crc_en    = (state == LOAD) && xfer && !cfg_abort;

  for (genvar k = 0; k < CW; k++) begin : g_exp
    assign exp_nxt[k*DATA_W +: DATA_W] =
      (wcnt == WRD_W'(k)) ? cfg_data : exp_crc[k*DATA_W +: DATA_W];
  end
  assign crc_ok = (exp_nxt[15:0] == crc);

  tile_cfg_crc16 #(.DATA_W(DATA_W)) u_crc (
    .clk  (prog_clk),
    .rst  (pReset),
    .clr  (crc_clr),
    .en   (crc_en),
    .data (cfg_data),
    .crc  (crc)
  );
`else
  assign cfg_ready = (state == LOAD);
  assign cfg_err   = 1'b0;
`endif

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state    <= IDLE;
      row      <= '0;
      wcnt     <= '0;
      pcnt     <= '0;
      col      <= '0;
      bl       <= '0;
      wl       <= '0;
      cfg_done <= 1'b0;
`ifdef CFG_CRC_EN
      cfg_err  <= 1'b0;
      exp_crc  <= '0;
`endif
    end else begin
      cfg_done <= 1'b0;
      if (state != IDLE && cfg_abort) begin
        // Abort wins over any transfer offered in the same cycle.
        state <= IDLE;
        wcnt  <= '0;
        bl    <= '0;
        wl    <= '0;
      end else begin
        case (state)
          IDLE: if (cfg_start) begin
            state   <= LOAD;
            row     <= '0;
            wcnt    <= '0;
`ifdef CFG_CRC_EN
            cfg_err <= 1'b0;
`endif
          end
          LOAD: if (xfer) begin
            col <= col_nxt;
            if (wcnt == WRD_W'(WPR - 1)) begin
              wcnt  <= '0;
              state <= SETUP;
              // Padding bits past NUM_BL in the last word are dropped here.
              for (int i = 0; i < NUM_BL; i++) bl[i] <= col_nxt[i];
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          SETUP: begin
            state   <= PULSE;
            pcnt    <= '0;
            wl[row] <= 1'b1;
          end
          PULSE: begin
            if (pcnt == PLS_W'(WL_PULSE - 1)) begin
              state <= HOLD;
              wl    <= '0;
            end else begin
              pcnt <= pcnt + 1'b1;
            end
          end
          HOLD: begin
            bl <= '0;
            if (last_row) begin
`ifdef CFG_CRC_EN
              state    <= CRC;
`else
              state    <= DONE;
              cfg_done <= 1'b1;
`endif
            end else begin
              row   <= row + 1'b1;
              state <= LOAD;
            end
          end
`ifdef CFG_CRC_EN
          CRC: if (xfer) begin
            exp_crc <= exp_nxt;
            if (wcnt == WRD_W'(CW - 1)) begin
              wcnt <= '0;
              if (crc_ok) begin
                state    <= DONE;
                cfg_done <= 1'b1;
              end else begin
                state   <= IDLE;
                cfg_err <= 1'b1;
              end
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
`endif
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
